// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register and ALU operand select.
// Captures decoded fields and builds the ALU operands with MEM/WB bypass.
// It also detects load-use hazards and turns flushes and hazards into bubbles.
// Build option: define FORWARD_EN to enable the MEM/WB bypass paths. When it
// is undefined, every RAW dependence on an in-flight writer stalls decode.
module id_ex_operand_stage #(
  parameter int XLEN   = 32,
  parameter int RIDX_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [RIDX_W-1:0] id_rs1,
  input  logic [RIDX_W-1:0] id_rs2,
  input  logic [RIDX_W-1:0] id_rd,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              id_reg_wen,
  input  logic              id_mem_read,
  input  logic              id_a_sel,
  input  logic              id_b_sel,
  input  logic [3:0]        id_alu_op,
  input  logic              mem_valid,
  input  logic              mem_reg_wen,
  input  logic [RIDX_W-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_result,
  input  logic              wb_valid,
  input  logic              wb_reg_wen,
  input  logic [RIDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_result,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [3:0]        alu_op,
  output logic [XLEN-1:0]   ex_store_data,
  output logic              ex_valid,
  output logic              ex_reg_wen,
  output logic              ex_mem_read,
  output logic [RIDX_W-1:0] ex_rd,
  output logic [XLEN-1:0]   ex_pc,
  output logic              hazard_stall
);

  logic              vld_p1;
  logic [XLEN-1:0]   pc_p1;
  logic [XLEN-1:0]   rs1_data_p1;
  logic [XLEN-1:0]   rs2_data_p1;
  logic [XLEN-1:0]   imm_p1;
  logic [RIDX_W-1:0] rs1_p1;
  logic [RIDX_W-1:0] rs2_p1;
  logic [RIDX_W-1:0] rd_p1;
  logic              a_sel_p1;
  logic              b_sel_p1;
  logic [3:0]        alu_op_p1;
  logic              reg_wen_p1;
  logic              mem_read_p1;

  logic              mem_wr;
  logic              wb_wr;
  logic              ex_wr;
  logic              load_use;
  logic              raw_any;
  logic [XLEN-1:0]   fwd_rs1;
  logic [XLEN-1:0]   fwd_rs2;

  // True when a source index names a live, nonzero writer destination.
  function automatic logic src_hit(input logic uses, input logic [RIDX_W-1:0] src,
                                   input logic wr, input logic [RIDX_W-1:0] dst);
    return uses & wr & (dst != '0) & (src == dst);
  endfunction

  // Bypass select: MEM beats WB, and x0 never takes a bypassed value.
  function automatic logic [XLEN-1:0] fwd_sel(input logic [RIDX_W-1:0] src,
                                               input logic [XLEN-1:0] reg_val,
                                               input logic m_wr, input logic [RIDX_W-1:0] m_rd,
                                               input logic [XLEN-1:0] m_val,
                                               input logic w_wr, input logic [RIDX_W-1:0] w_rd,
                                               input logic [XLEN-1:0] w_val);
    if (src_hit(1'b1, src, m_wr, m_rd))      return m_val;
    else if (src_hit(1'b1, src, w_wr, w_rd)) return w_val;
    else                                     return reg_val;
  endfunction

  assign mem_wr = mem_valid & mem_reg_wen;
  assign wb_wr  = wb_valid & wb_reg_wen;
  assign ex_wr  = vld_p1 & reg_wen_p1;

  assign load_use = vld_p1 & mem_read_p1 & (rd_p1 != '0) & id_valid &
                    ((id_uses_rs1 & (id_rs1 == rd_p1)) | (id_uses_rs2 & (id_rs2 == rd_p1)));

`ifdef FORWARD_EN
  assign raw_any = 1'b0;
  assign fwd_rs1 = fwd_sel(rs1_p1, rs1_data_p1, mem_wr, mem_rd, mem_result,
                           wb_wr, wb_rd, wb_result);
  assign fwd_rs2 = fwd_sel(rs2_p1, rs2_data_p1, mem_wr, mem_rd, mem_result,
                           wb_wr, wb_rd, wb_result);
`else
  // Without bypass, decode waits until no in-flight stage writes a source.
  assign raw_any = id_valid &
                   (src_hit(id_uses_rs1, id_rs1, ex_wr,  rd_p1)  |
                    src_hit(id_uses_rs1, id_rs1, mem_wr, mem_rd) |
                    src_hit(id_uses_rs1, id_rs1, wb_wr,  wb_rd)  |
                    src_hit(id_uses_rs2, id_rs2, ex_wr,  rd_p1)  |
                    src_hit(id_uses_rs2, id_rs2, mem_wr, mem_rd) |
                    src_hit(id_uses_rs2, id_rs2, wb_wr,  wb_rd));
  assign fwd_rs1 = rs1_data_p1;
  assign fwd_rs2 = rs2_data_p1;

  logic unused_nofwd;
  assign unused_nofwd = ^{mem_result, wb_result, rs1_p1, rs2_p1};
`endif

  assign hazard_stall = load_use | raw_any;

  // EX register: reset, then flush bubble, hold on stall, hazard bubble, load.
  always_ff @(posedge clk) begin
    if (rst || flush || (!stall && hazard_stall)) begin
      vld_p1      <= 1'b0;
      pc_p1       <= '0;
      rs1_data_p1 <= '0;
      rs2_data_p1 <= '0;
      imm_p1      <= '0;
      rs1_p1      <= '0;
      rs2_p1      <= '0;
      rd_p1       <= '0;
      a_sel_p1    <= 1'b0;
      b_sel_p1    <= 1'b0;
      alu_op_p1   <= 4'b0000;
      reg_wen_p1  <= 1'b0;
      mem_read_p1 <= 1'b0;
    end else if (!stall) begin
      vld_p1      <= id_valid;
      pc_p1       <= id_pc;
      rs1_data_p1 <= id_rs1_data;
      rs2_data_p1 <= id_rs2_data;
      imm_p1      <= id_imm;
      rs1_p1      <= id_rs1;
      rs2_p1      <= id_rs2;
      rd_p1       <= id_rd;
      a_sel_p1    <= id_a_sel;
      b_sel_p1    <= id_b_sel;
      alu_op_p1   <= id_alu_op;
      reg_wen_p1  <= id_reg_wen;
      mem_read_p1 <= id_mem_read;
    end
  end

  // ---- EX stage: operand select from registered fields plus bypass ----
  assign alu_a         = a_sel_p1 ? pc_p1 : fwd_rs1;
  assign alu_b         = b_sel_p1 ? imm_p1 : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign alu_op        = alu_op_p1;
  assign ex_valid      = vld_p1;
  assign ex_reg_wen    = reg_wen_p1;
  assign ex_mem_read   = mem_read_p1;
  assign ex_rd         = rd_p1;
  assign ex_pc         = pc_p1;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage; expectations follow FORWARD_EN.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_uses_rs1, id_uses_rs2, id_reg_wen, id_mem_read, id_a_sel, id_b_sel;
  logic [3:0]  id_alu_op;
  logic        mem_valid, mem_reg_wen, wb_valid, wb_reg_wen;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_result, wb_result;
  logic [31:0] alu_a, alu_b, ex_store_data, ex_pc;
  logic [3:0]  alu_op;
  logic        ex_valid, ex_reg_wen, ex_mem_read, hazard_stall;
  logic [4:0]  ex_rd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.XLEN(32), .RIDX_W(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_reg_wen(id_reg_wen), .id_mem_read(id_mem_read), .id_a_sel(id_a_sel),
    .id_b_sel(id_b_sel), .id_alu_op(id_alu_op),
    .mem_valid(mem_valid), .mem_reg_wen(mem_reg_wen), .mem_rd(mem_rd),
    .mem_result(mem_result), .wb_valid(wb_valid), .wb_reg_wen(wb_reg_wen),
    .wb_rd(wb_rd), .wb_result(wb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .ex_store_data(ex_store_data),
    .ex_valid(ex_valid), .ex_reg_wen(ex_reg_wen), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .ex_pc(ex_pc), .hazard_stall(hazard_stall)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, rs1d, rs2d, imm,
                        input logic [4:0] rs1, rs2, rd,
                        input logic u1, u2, wen, mrd, asel, bsel,
                        input logic [3:0] op);
    id_valid = v; id_pc = pc; id_rs1_data = rs1d; id_rs2_data = rs2d; id_imm = imm;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_reg_wen = wen; id_mem_read = mrd;
    id_a_sel = asel; id_b_sel = bsel; id_alu_op = op;
  endtask

  task automatic set_mem(input logic v, input logic wen, input logic [4:0] rd, input logic [31:0] res);
    mem_valid = v; mem_reg_wen = wen; mem_rd = rd; mem_result = res;
  endtask

  task automatic set_wb(input logic v, input logic wen, input logic [4:0] rd, input logic [31:0] res);
    wb_valid = v; wb_reg_wen = wen; wb_rd = rd; wb_result = res;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_mem(0, 0, 0, 0);
    set_wb(0, 0, 0, 0);
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset with random decode activity
    for (int i = 0; i < 2; i++) begin
      set_id(1'($urandom), $urandom, $urandom, $urandom, $urandom,
             5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
      tick();
    end
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_store", ex_store_data, 32'd0);
    check("rst_hazard", 32'(hazard_stall), 32'd0);
    check("rst_ex_pc", ex_pc, 32'd0);
    check("rst_ex_rd", 32'(ex_rd), 32'd0);
    rst = 1'b0;

    // Plain register operands
    set_id(1, 32'h100, 32'h11, 32'h22, 32'h33, 1, 2, 4, 1, 1, 1, 0, 0, 0, 4'h0);
    tick();
    check("a_ex_valid", 32'(ex_valid), 32'd1);
    check("a_ex_pc", ex_pc, 32'h100);
    check("a_ex_rd", 32'(ex_rd), 32'd4);
    check("a_ex_wen", 32'(ex_reg_wen), 32'd1);
    check("a_alu_a", alu_a, 32'h11);
    check("a_alu_b", alu_b, 32'h22);
    check("a_store", ex_store_data, 32'h22);

    // pc / imm operand select
    set_id(1, 32'h104, 32'h11, 32'h22, 32'h33, 1, 2, 4, 1, 1, 1, 0, 1, 1, 4'hF);
    tick();
    check("b_alu_a_pc", alu_a, 32'h104);
    check("b_alu_b_imm", alu_b, 32'h33);
    check("b_store_rs2", ex_store_data, 32'h22);
    check("b_alu_op", 32'(alu_op), 32'hF);

    // MEM over WB priority, then WB alone
    set_id(1, 32'h108, 32'h1, 32'h2, 32'h0, 5, 6, 9, 1, 1, 1, 0, 0, 0, 4'h8);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_mem(1, 1, 5, 32'h0000_00AA);
    set_wb(1, 1, 5, 32'h0000_0055);
    #1;
`ifdef FORWARD_EN
    check("fwd_mem_prio", alu_a, 32'h0000_00AA);
`else
    check("fwd_mem_prio", alu_a, 32'h1);
`endif
    check("fwd_no_hazard", 32'(hazard_stall), 32'd0);
    set_mem(0, 0, 0, 0);
    set_wb(1, 1, 6, 32'h0000_0055);
    #1;
`ifdef FORWARD_EN
    check("fwd_wb_b", alu_b, 32'h0000_0055);
    check("fwd_wb_store", ex_store_data, 32'h0000_0055);
`else
    check("fwd_wb_b", alu_b, 32'h2);
    check("fwd_wb_store", ex_store_data, 32'h2);
`endif
    check("fwd_wb_a", alu_a, 32'h1);
    set_wb(0, 0, 0, 0);

    // x0 is never bypassed
    set_id(1, 32'h10C, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 4'h0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_mem(1, 1, 0, 32'hDEAD_BEEF);
    set_wb(1, 1, 0, 32'hDEAD_BEEF);
    #1;
    check("x0_alu_b", alu_b, 32'd0);
    check("x0_store", ex_store_data, 32'd0);
    check("x0_alu_a", alu_a, 32'd0);
    set_mem(0, 0, 0, 0);
    set_wb(0, 0, 0, 0);

    // Load-use: lw x7 in EX, add reading x7 in ID
    set_id(1, 32'h110, 32'h1000, 0, 32'h4, 8, 0, 7, 1, 0, 1, 1, 0, 1, 4'h0);
    tick();
    set_id(1, 32'h200, 32'h5, 32'h0, 0, 1, 7, 10, 1, 1, 1, 0, 0, 0, 4'h0);
    #1;
    check("lu_hazard", 32'(hazard_stall), 32'd1);
    tick();
    check("lu_bubble_valid", 32'(ex_valid), 32'd0);
    check("lu_bubble_mrd", 32'(ex_mem_read), 32'd0);
    check("lu_bubble_pc", ex_pc, 32'd0);
    set_mem(1, 1, 7, 32'h77);
    #1;
`ifdef FORWARD_EN
    check("lu_hazard_clear", 32'(hazard_stall), 32'd0);
    tick();
    set_mem(0, 0, 0, 0);
    set_wb(1, 1, 7, 32'h77);
    #1;
`else
    check("lu_hazard_mem", 32'(hazard_stall), 32'd1);
    tick();
    check("lu_bubble2_valid", 32'(ex_valid), 32'd0);
    set_mem(0, 0, 0, 0);
    set_wb(1, 1, 7, 32'h77);
    #1;
    check("lu_hazard_wb", 32'(hazard_stall), 32'd1);
    tick();
    set_wb(0, 0, 0, 0);
    id_rs2_data = 32'h77;
    #1;
    check("lu_hazard_clear", 32'(hazard_stall), 32'd0);
    tick();
`endif
    check("lu_add_valid", 32'(ex_valid), 32'd1);
    check("lu_add_pc", ex_pc, 32'h200);
    check("lu_add_alu_b", alu_b, 32'h77);
    check("lu_add_alu_a", alu_a, 32'h5);
    set_wb(0, 0, 0, 0);

    // Non-load RAW on x3
    set_id(1, 32'h300, 32'h9, 32'h9, 0, 11, 12, 3, 1, 1, 1, 0, 0, 0, 4'h0);
    tick();
    set_id(1, 32'h304, 32'h3C, 32'h1, 0, 3, 13, 14, 1, 1, 1, 0, 0, 0, 4'h0);
    #1;
`ifdef FORWARD_EN
    check("raw_no_hazard", 32'(hazard_stall), 32'd0);
    tick();
`else
    check("raw_hazard_ex", 32'(hazard_stall), 32'd1);
    tick();
    check("raw_bubble", 32'(ex_valid), 32'd0);
    set_mem(1, 1, 3, 32'h3C);
    #1;
    check("raw_hazard_mem", 32'(hazard_stall), 32'd1);
    tick();
    set_mem(0, 0, 0, 0);
    set_wb(1, 1, 3, 32'h3C);
    #1;
    check("raw_hazard_wb", 32'(hazard_stall), 32'd1);
    tick();
    set_wb(0, 0, 0, 0);
    #1;
    check("raw_hazard_clear", 32'(hazard_stall), 32'd0);
    tick();
`endif
    check("raw_enter_pc", ex_pc, 32'h304);
    check("raw_enter_valid", 32'(ex_valid), 32'd1);
    check("raw_enter_alu_a", alu_a, 32'h3C);

    // flush + stall together: flush wins
    set_id(1, 32'h400, 32'h1, 32'h2, 0, 1, 2, 15, 1, 1, 1, 0, 0, 0, 4'h0);
    flush = 1'b1; stall = 1'b1;
    tick();
    check("fs_valid", 32'(ex_valid), 32'd0);
    check("fs_pc", ex_pc, 32'd0);
    check("fs_wen", 32'(ex_reg_wen), 32'd0);
    flush = 1'b0; stall = 1'b0;
    tick();
    check("ld_pc", ex_pc, 32'h400);
    check("ld_rd", 32'(ex_rd), 32'd15);

    // stall alone holds everything
    stall = 1'b1;
    set_id(1, 32'h500, 32'h7, 32'h7, 32'h7, 16, 17, 18, 1, 1, 1, 1, 1, 1, 4'h3);
    tick();
    check("st_pc", ex_pc, 32'h400);
    check("st_rd", 32'(ex_rd), 32'd15);
    check("st_valid", 32'(ex_valid), 32'd1);
    check("st_alu_op", 32'(alu_op), 32'd0);
    check("st_mrd", 32'(ex_mem_read), 32'd0);
    check("st_alu_a", alu_a, 32'h1);

    // Reset mid-operation beats stall and flush
    flush = 1'b1;
    rst = 1'b1;
    tick();
    check("mr_valid", 32'(ex_valid), 32'd0);
    check("mr_pc", ex_pc, 32'd0);
    check("mr_rd", 32'(ex_rd), 32'd0);
    rst = 1'b0; stall = 1'b0; flush = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
